// File: rtl/fwd_ctrl_unit_pkg.sv
// Shared processor package: operand-select encodings for the shifter and the
// ALU-side forwarding paths, plus small helpers used by the forwarding control.
package fwd_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        FWD_SHIFT = 2'b00,
        FWD_DATA1 = 2'b01,
        FWD_REGF  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RES_SHIFT = 1'b0,
        RES_DATA1 = 1'b1
    } res_sel_e;

    // Pick the operand source for a consumer given the producer's result source.
    function automatic fwd_sel_e fwd_select(input logic match, input res_sel_e sel);
        if (!match) begin
            return FWD_REGF;
        end
        return (sel == RES_DATA1) ? FWD_DATA1 : FWD_SHIFT;
    endfunction

    function automatic logic is_forwarded(input fwd_sel_e sel);
        return sel != FWD_REGF;
    endfunction

endpackage

// File: rtl/fwd_ctrl_unit_sat_counter.sv
// Saturating up-counter: advances on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Forwarding control for the shifter operand: tracks the instruction in EX and
// registers the operand select for the instruction issuing from ID.
module fwd_ctrl_unit
    import fwd_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src_reg,
    input  logic [REG_AW-1:0] id_dst_reg,
    input  logic              id_wr_en,
    input  logic              id_res_sel,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        fwd_ctrl,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic              ex_hazard
);

    logic              ex_valid;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_wr;
    res_sel_e          ex_sel;

    fwd_sel_e          fwd_q;
    fwd_sel_e          fwd_d;
    logic              match;
    logic              advance;
    logic              cnt_inc;

    assign match   = id_valid & ex_valid & ex_wr & (id_src_reg == ex_dst);
    assign fwd_d   = fwd_select(match, ex_sel);
    assign advance = ~stall & ~flush;
    assign cnt_inc = advance & is_forwarded(fwd_d);

    // NOTE: non-blocking updates mean the compare always sees the older EX
    // instruction, so a self-dependent ID instruction never matches itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q     <= FWD_REGF;
            ex_hazard <= 1'b0;
            ex_valid  <= 1'b0;
            ex_dst    <= '0;
            ex_wr     <= 1'b0;
            ex_sel    <= RES_SHIFT;
        end else if (flush) begin
            fwd_q     <= FWD_REGF;
            ex_hazard <= 1'b0;
            ex_valid  <= 1'b0;
        end else if (!stall) begin
            fwd_q     <= fwd_d;
            ex_hazard <= is_forwarded(fwd_d);
            ex_valid  <= id_valid;
            ex_dst    <= id_dst_reg;
            ex_wr     <= id_wr_en;
            ex_sel    <= res_sel_e'(id_res_sel);
        end
    end

    assign fwd_ctrl = fwd_q;

    sat_counter #(
        .W(CNT_W)
    ) u_fwd_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .count(fwd_cnt)
    );

endmodule
